palette_processor: RTL and testbench

PALETTE_PROCESSOR -- requirements
Module: palette_processor

---
 rtl/palette_processor_pkg.sv | 33 +++
 rtl/palette_processor_nibble_shift_reg.sv | 47 ++++
 rtl/palette_processor.sv | 160 ++++++++++++++++
 tb/tb_palette_processor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/palette_processor_pkg.sv
// -----------------------------------------------------------------------------
// palette_processor_pkg
// Shared project constants for the palette processor:
//   - register-bus address map (entry index, nibble write, nibble read)
//   - write-FSM state encodings
//   - power-up colour table (red, green, blue, white repeating by index)
// -----------------------------------------------------------------------------
package palette_processor_pkg;

   // Register-bus address map.
   localparam logic [3:0] BUS_ADDR_IDX = 4'hA;
   localparam logic [3:0] BUS_ADDR_WR  = 4'hB;
   localparam logic [3:0] BUS_ADDR_RD  = 4'hC;

   // Write FSM encodings.
   typedef logic [1:0] wr_state_t;
   localparam wr_state_t ST_IDLE    = 2'd0;
   localparam wr_state_t ST_COLLECT = 2'd1;
   localparam wr_state_t ST_COMMIT  = 2'd2;

   // Power-up colour of palette slot idx (24-bit RGB; callers resize).
   function automatic logic [23:0] default_color(input int unsigned idx);
      logic [23:0] c;
      case (idx % 4)
         0:       c = 24'hFF0000;
         1:       c = 24'h00FF00;
         2:       c = 24'h0000FF;
         default: c = 24'hFFFFFF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/palette_processor_nibble_shift_reg.sv
// -----------------------------------------------------------------------------
// nibble_shift_reg
// Shadow register assembled one nibble at a time, MSB nibble first. The
// pointer starts at the MSB nibble, steps down on each load and wraps back
// to the MSB after nibble 0, so the next entry can start immediately.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset (shadow=0, pointer=MSB)
//   clear   in   discard partial shadow, pointer back to MSB
//   load    in   store nibble at the pointer and advance
//   nibble  in   4-bit data to store
//   shadow  out  assembled COLOR_W-bit value
//   last    out  pointer is at nibble 0 (the next load completes the word)
// -----------------------------------------------------------------------------
module nibble_shift_reg #(
   parameter int COLOR_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               load,
   input  logic [3:0]         nibble,
   output logic [COLOR_W-1:0] shadow,
   output logic               last
);

   localparam int NIB_N = COLOR_W / 4;
   localparam int PTR_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
   localparam logic [PTR_W-1:0] PTR_MSB = PTR_W'(NIB_N - 1);

   logic [PTR_W-1:0] ptr;

   assign last = (ptr == '0);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         shadow <= '0;
         ptr    <= PTR_MSB;
      end else if (load) begin
         shadow[{ptr, 2'b00} +: 4] <= nibble;
         ptr <= last ? PTR_MSB : ptr - 1'b1;
      end
   end

endmodule

// File: rtl/palette_processor.sv
// -----------------------------------------------------------------------------
// palette_processor
// Colour palette of NUM_COLORS entries, loaded and read a nibble at a time
// over a 4-bit register bus, and rotatable one slot per color_next pulse.
// Ports:
//   clk             in   system clock (rising edge)
//   rst             in   synchronous active-high reset
//   address         in   4-bit bus address, qualified by valid
//   data            in   4-bit bus write nibble, qualified by valid
//   valid           in   one-cycle transaction strobe
//   ack             out  one-cycle acknowledge, cycle after an accepted valid
//   data_out        out  read nibble, zero unless data_out_valid
//   data_out_valid  out  qualifier for data_out (same cycle as ack)
//   color_next      in   one-cycle pulse: rotate the palette
//   rot_dir         in   0 = entries move toward lower index, 1 = higher
//   rgb_flat        out  entry i on bits [i*COLOR_W +: COLOR_W]
//   busy            out  commit in progress or rotate deferred
// -----------------------------------------------------------------------------
module palette_processor
   import palette_processor_pkg::*;
#(
   parameter int         NUM_COLORS = 4,
   parameter int         COLOR_W    = 24,
   parameter logic [3:0] ADDR_IDX   = BUS_ADDR_IDX,
   parameter logic [3:0] ADDR_WR    = BUS_ADDR_WR,
   parameter logic [3:0] ADDR_RD    = BUS_ADDR_RD
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    address,
   input  logic [3:0]                    data,
   input  logic                          valid,
   output logic                          ack,
   output logic [3:0]                    data_out,
   output logic                          data_out_valid,
   input  logic                          color_next,
   input  logic                          rot_dir,
   output logic [NUM_COLORS*COLOR_W-1:0] rgb_flat,
   output logic                          busy
);

   localparam int NIB_N = COLOR_W / 4;
   localparam int PTR_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
   localparam int IDX_W = $clog2(NUM_COLORS);
   localparam logic [PTR_W-1:0] PTR_MSB = PTR_W'(NIB_N - 1);

   logic               is_idx, is_wr, is_rd;
   wr_state_t          state;
   logic [IDX_W-1:0]   index;
   logic [PTR_W-1:0]   rd_ptr;
   logic [COLOR_W-1:0] shadow;
   logic [COLOR_W-1:0] rd_word;
   logic               wr_last;
   logic               commit;
   logic               do_rot;
   logic               rot_dir_eff;
   logic               rot_pending;
   logic               rot_dir_q;
   logic [COLOR_W-1:0] entries [NUM_COLORS];

   // Bus decode: any other address is silently ignored.
   assign is_idx = valid && (address == ADDR_IDX);
   assign is_wr  = valid && (address == ADDR_WR);
   assign is_rd  = valid && (address == ADDR_RD);

   assign commit      = (state == ST_COMMIT);
   // A commit owns the entry array for its cycle; a coincident rotate waits
   // one cycle, and while one is waiting further pulses are dropped.
   assign do_rot      = !commit && (rot_pending || color_next);
   assign rot_dir_eff = rot_pending ? rot_dir_q : rot_dir;
   assign busy        = commit || rot_pending;
   assign rd_word     = entries[index];

   nibble_shift_reg #(.COLOR_W(COLOR_W)) u_shift (
      .clk    (clk),
      .rst    (rst),
      .clear  (is_idx),
      .load   (is_wr),
      .nibble (data),
      .shadow (shadow),
      .last   (wr_last)
   );

   // Write FSM. A new first nibble may arrive in the COMMIT cycle: the copy
   // reads the old shadow while the new nibble lands at the MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (is_idx) begin
         state <= ST_IDLE;
      end else if (is_wr) begin
         state <= wr_last ? ST_COMMIT : ST_COLLECT;
      end else if (commit) begin
         state <= ST_IDLE;
      end
   end

   // Index, read pointer and bus responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         index          <= '0;
         rd_ptr         <= PTR_MSB;
         ack            <= 1'b0;
         data_out       <= 4'h0;
         data_out_valid <= 1'b0;
      end else begin
         ack            <= is_idx || is_wr || is_rd;
         data_out_valid <= is_rd;
         data_out       <= is_rd ? rd_word[{rd_ptr, 2'b00} +: 4] : 4'h0;
         if (is_idx) begin
            index  <= IDX_W'(32'(data) % 32'(NUM_COLORS));
            rd_ptr <= PTR_MSB;
         end else if (is_rd) begin
            rd_ptr <= (rd_ptr == '0) ? PTR_MSB : rd_ptr - 1'b1;
         end
      end
   end

   // Deferred rotate: only a commit can force a deferral, and a commit is
   // never followed directly by another commit, so one pending slot suffices.
   always_ff @(posedge clk) begin
      if (rst) begin
         rot_pending <= 1'b0;
         rot_dir_q   <= 1'b0;
      end else begin
         rot_pending <= commit && color_next;
         if (commit && color_next) begin
            rot_dir_q <= rot_dir;
         end
      end
   end

   // Palette entries.
   // NOTE: this array is reset explicitly because the power-up palette is
   // visible behaviour; it is therefore built from flops, not a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_COLORS; i++) begin
            entries[i] <= COLOR_W'(default_color(i));
         end
      end else if (commit) begin
         entries[index] <= shadow;
      end else if (do_rot) begin
         for (int i = 0; i < NUM_COLORS; i++) begin
            entries[i] <= rot_dir_eff ? entries[(i + NUM_COLORS - 1) % NUM_COLORS]
                                      : entries[(i + 1) % NUM_COLORS];
         end
      end
   end

   // NOTE: combinational blocks assign a default first so no path can
   // leave an output unassigned and infer a latch.
   always_comb begin
      rgb_flat = '0;
      for (int i = 0; i < NUM_COLORS; i++) begin
         rgb_flat[i*COLOR_W +: COLOR_W] = entries[i];
      end
   end

endmodule

// File: tb/tb_palette_processor.sv
// -----------------------------------------------------------------------------
// tb_palette_processor
// Directed bench for palette_processor (default parameters: 4 x 24-bit).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_palette_processor;

   localparam logic [3:0] A_IDX = 4'hA;
   localparam logic [3:0] A_WR  = 4'hB;
   localparam logic [3:0] A_RD  = 4'hC;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  address;
   logic [3:0]  data;
   logic        valid;
   logic        ack;
   logic [3:0]  data_out;
   logic        data_out_valid;
   logic        color_next;
   logic        rot_dir;
   logic [95:0] rgb_flat;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   int rd_exp [7] = '{1, 2, 3, 4, 5, 6, 1};

   always #5 clk = ~clk;

   palette_processor dut (
      .clk            (clk),
      .rst            (rst),
      .address        (address),
      .data           (data),
      .valid          (valid),
      .ack            (ack),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .color_next     (color_next),
      .rot_dir        (rot_dir),
      .rgb_flat       (rgb_flat),
      .busy           (busy)
   );

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bus transaction; valid drops afterwards unless the caller issues
   // another bus() immediately (back-to-back).
   task automatic bus(input logic [3:0] a, input logic [3:0] d);
      valid   = 1'b1;
      address = a;
      data    = d;
      tick();
      valid   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; address = 4'h0; data = 4'h0;
      color_next = 1'b0; rot_dir = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state.
      check("reset_rgb", rgb_flat, {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000});
      check("reset_hs", {ack, data_out_valid, busy, data_out}, '0);

      // Write 0x123456 into entry 2.
      bus(A_IDX, 4'd2);
      check("idx_ack", ack, 1);
      for (int k = 1; k <= 6; k++) begin
         bus(A_WR, 4'(k));
         check($sformatf("wr_ack%0d", k), ack, 1);
      end
      check("partial_hidden", rgb_flat, {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000});
      check("commit_busy_a", busy, 1);
      tick();
      check("commit_rgb", rgb_flat, {24'hFFFFFF, 24'h123456, 24'h00FF00, 24'hFF0000});
      check("commit_idle", {ack, busy}, '0);

      // Read entry 2 back, seven nibbles with wrap.
      bus(A_IDX, 4'd2);
      for (int i = 0; i < 7; i++) begin
         bus(A_RD, 4'h0);
         check($sformatf("rd%0d", i), {ack, data_out_valid, data_out}, {1'b1, 1'b1, 4'(rd_exp[i])});
      end
      tick();
      check("rd_idle", {ack, data_out_valid, data_out}, '0);
      bus(4'h3, 4'h5);
      check("bad_addr", {ack, data_out_valid, data_out}, '0);

      // Rotation from reset, both directions.
      rst = 1'b1; tick(); rst = 1'b0;
      color_next = 1'b1; rot_dir = 1'b0; tick(); color_next = 1'b0;
      check("rot_down", rgb_flat, {24'hFF0000, 24'hFFFFFF, 24'h0000FF, 24'h00FF00});
      color_next = 1'b1; rot_dir = 1'b1; tick(); color_next = 1'b0;
      check("rot_up", rgb_flat, {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000});

      // Rotate coinciding with COMMIT: commit first, rotate deferred.
      bus(A_IDX, 4'd1);
      for (int k = 10; k <= 15; k++) bus(A_WR, 4'(k));
      check("commit_busy_b", busy, 1);
      color_next = 1'b1; rot_dir = 1'b0; tick();
      check("commit_first", rgb_flat, {24'hFFFFFF, 24'h0000FF, 24'hABCDEF, 24'hFF0000});
      check("defer_busy", busy, 1);
      rot_dir = 1'b1; tick(); color_next = 1'b0;
      check("deferred_rot", rgb_flat, {24'hFF0000, 24'hFFFFFF, 24'h0000FF, 24'hABCDEF});
      check("defer_done", busy, 0);
      tick();
      check("second_dropped", rgb_flat, {24'hFF0000, 24'hFFFFFF, 24'h0000FF, 24'hABCDEF});
      // Index still addresses physical slot 1 (now 0000FF).
      bus(A_RD, 4'h0);
      check("idx_fixed", {ack, data_out_valid, data_out}, {1'b1, 1'b1, 4'h0});

      // Reset during COLLECT aborts the write.
      bus(A_IDX, 4'd3);
      for (int k = 0; k < 3; k++) bus(A_WR, 4'h7);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_abort", rgb_flat, {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000});
      for (int k = 9; k >= 4; k--) bus(A_WR, 4'(k));
      tick();
      check("fresh_commit", rgb_flat, {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'h987654});

      // Index is taken modulo NUM_COLORS: 12 selects entry 0.
      bus(A_IDX, 4'hC);
      bus(A_RD, 4'h0);
      check("idx_mod", {ack, data_out_valid, data_out}, {1'b1, 1'b1, 4'h9});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
